// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the two-tap 8-bit LFSR generator.
// Self-synchronises on the incoming bit stream (SEARCH), then free-runs its
// own copy of the sequence (LOCKED) and counts received bits that disagree.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bit_in       received serial PRBS bit (generator bit 0)
//   bit_valid    bit_in is consumed only on edges where this is high
//   clear_count  synchronous clear of err_count (wins over an increment)
//   locked       checker is synchronised
//   bit_error    one-cycle pulse: bit just accepted while locked mismatched
//   lock_lost    one-cycle pulse on the LOCKED -> SEARCH transition
//   err_count    saturating count of errors seen while locked
module prbs_checker #(
  parameter int TAP_ONE     = 2,
  parameter int TAP_TWO     = 4,
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 32,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_count,
  output logic             locked,
  output logic             bit_error,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t     state;
  logic [7:0] hist;       // hist[0] oldest, hist[7] newest
  logic [3:0] fill;
  logic [7:0] match_cnt;
  logic [7:0] win_cnt;
  logic [7:0] win_errs;

  logic expected, mis, lose, err_inc;

  // Generator relation: b[n+8] = b[n] ^ b[n+TAP_ONE] ^ b[n+TAP_TWO]
  assign expected = hist[0] ^ hist[TAP_ONE] ^ hist[TAP_TWO];
  assign mis      = bit_in ^ expected;
  // Current error included when judging the window threshold
  assign lose     = mis && ((win_errs + 8'd1) >= 8'(LOSS_THRESH));
  assign err_inc  = bit_valid && (state == LOCKED) && mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      bit_error <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      bit_error <= 1'b0;
      lock_lost <= 1'b0;

      if (bit_valid) begin
        case (state)
          SEARCH: begin
            hist <= {bit_in, hist[7:1]};
            if (fill < 4'd8) begin
              fill <= fill + 4'd1;
            end else if (!mis && (hist != 8'd0)) begin
              // An all-zero history predicts zeros forever, so it never counts
              if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            // Flywheel: feed back the prediction so a line error stays a
            // single error instead of corrupting later predictions.
            hist <= {expected, hist[7:1]};
            if (mis) bit_error <= 1'b1;
            if (lose) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              fill      <= '0;
              match_cnt <= '0;
            end else if (win_cnt == 8'(WINDOW - 1)) begin
              win_cnt  <= '0;
              win_errs <= '0;
            end else begin
              win_cnt  <= win_cnt + 8'd1;
              win_errs <= win_errs + {7'd0, mis};
            end
          end

          default: state <= SEARCH;
        endcase
      end

      if (clear_count)
        err_count <= '0;
      else if (err_inc && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed phases with random valid gaps / error placement,
// checked every cycle against a queue-based reference model of the checker.
module tb_prbs_checker;

  localparam int T1 = 2, T2 = 4, LC = 16, WIN = 32, LT = 8, CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          clear_count = 1'b0;
  logic          locked, bit_error, lock_lost;
  logic [CW-1:0] err_count;

  prbs_checker #(.TAP_ONE(T1), .TAP_TWO(T2), .LOCK_COUNT(LC), .WINDOW(WIN),
                 .LOSS_THRESH(LT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_count(clear_count), .locked(locked), .bit_error(bit_error),
    .lock_lost(lock_lost), .err_count(err_count));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // Generator stream: initial state 0x01 emitted LSB first, then recurrence
  int gen[4096];
  int gi;

  // Reference model
  int h[$];
  int m_lock, m_fill, m_match, m_wcnt, m_werr, m_ec, m_be, m_ll;

  // Observation helpers
  int vcnt, lock_at, be_cnt, ll_cnt, prev_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h = {};
    for (int i = 0; i < 8; i++) h.push_back(0);
    m_lock = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
    m_ec = 0; m_be = 0; m_ll = 0;
  endtask

  task automatic model_step(input int v, input int b, input int clr);
    int e, allz, err;
    m_be = 0; m_ll = 0;
    if (v != 0) begin
      e = h[0] ^ h[T1] ^ h[T2];
      allz = (h.sum() == 0);
      void'(h.pop_front());
      if (m_lock == 0) begin
        h.push_back(b);
        if (m_fill < 8) m_fill++;
        else if (b == e && !allz) begin
          m_match++;
          if (m_match == LC) begin
            m_lock = 1; m_match = 0; m_wcnt = 0; m_werr = 0;
          end
        end else m_match = 0;
      end else begin
        h.push_back(e);
        err = (b != e);
        if (err != 0) begin
          m_be = 1;
          if (m_ec < (1 << CW) - 1) m_ec++;
        end
        if (err != 0 && m_werr + 1 >= LT) begin
          m_lock = 0; m_ll = 1; m_fill = 0; m_match = 0;
        end else if (m_wcnt == WIN - 1) begin
          m_wcnt = 0; m_werr = 0;
        end else begin
          m_wcnt++; m_werr += err;
        end
      end
    end
    if (clr != 0) m_ec = 0;
  endtask

  task automatic check_all();
    chk("locked", {31'd0, locked}, m_lock);
    chk("bit_error", {31'd0, bit_error}, m_be);
    chk("lock_lost", {31'd0, lock_lost}, m_ll);
    chk("err_count", {16'd0, err_count}, m_ec);
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    @(negedge clk);
    bit_valid = v; bit_in = b; clear_count = clr;
    @(posedge clk);
    model_step(v, b, clr);
    if (v) vcnt++;
    #1;
    check_all();
    if (locked && prev_locked == 0 && lock_at < 0) lock_at = vcnt;
    prev_locked = locked;
    if (bit_error) be_cnt++;
    if (lock_lost) ll_cnt++;
  endtask

  task automatic send(input int flip, input int clr);
    step(1'b1, 1'(gen[gi] ^ flip), 1'(clr));
    gi++;
  endtask

  task automatic mark();
    vcnt = 0; lock_at = -1; be_cnt = 0; ll_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bit_valid = 1'b0; clear_count = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    gi = 0; prev_locked = 0;
    mark();
  endtask

  initial begin
    int s;
    for (int i = 0; i < 8; i++) gen[i] = (i == 0) ? 1 : 0;
    for (int i = 8; i < 4096; i++) gen[i] = gen[i-8] ^ gen[i-8+T1] ^ gen[i-8+T2];

    // 1: clean stream locks on the 24th valid bit, no errors for 1000 bits
    do_reset();
    for (int i = 0; i < 1000; i++) send(0, 0);
    chk("lock_point_clean", 32'(lock_at), 32'd24);
    chk("no_errors_clean", 32'(be_cnt), 32'd0);
    chk("err_count_clean", {16'd0, err_count}, 32'd0);

    // 2: single inverted bit at stream index 100
    do_reset();
    for (int i = 0; i < 200; i++) send(i == 100 ? 1 : 0, 0);
    chk("single_err_pulses", 32'(be_cnt), 32'd1);
    chk("single_err_count", {16'd0, err_count}, 32'd1);
    chk("single_err_locked", {31'd0, locked}, 32'd1);

    // 3: all-zero stream never locks; clean stream then locks within 24 bits
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    chk("zeros_unlocked", {31'd0, locked}, 32'd0);
    chk("zeros_err_count", {16'd0, err_count}, 32'd0);
    gi = 0; mark();
    for (int i = 0; i < 40; i++) send(0, 0);
    n_assert++;
    assert (lock_at > 0 && lock_at <= 24) else begin
      n_fail++;
      $error("FAIL zeros_then_lock: observed %0d expected 1..24", lock_at);
    end

    // 4: eight consecutive errors drop lock; relock 24 bits later
    do_reset();
    for (int i = 0; i < 30; i++) send(0, 0);
    mark();
    for (int i = 0; i < 8; i++) send(1, 0);
    chk("burst_pulses", 32'(be_cnt), 32'd8);
    chk("burst_lock_lost", 32'(ll_cnt), 32'd1);
    chk("burst_unlocked", {31'd0, locked}, 32'd0);
    mark();
    for (int i = 0; i < 40; i++) send(0, 0);
    chk("relock_point", 32'(lock_at), 32'd24);
    chk("relock_err_kept", {16'd0, err_count}, 32'd8);

    // 5: seven errors per window for ten windows keeps lock
    do_reset();
    for (int i = 0; i < 24; i++) send(0, 0);
    mark();
    for (int w = 0; w < 10; w++) begin
      s = $urandom_range(0, WIN - 7);
      for (int i = 0; i < WIN; i++) send((i >= s && i < s + 7) ? 1 : 0, 0);
    end
    chk("window_locked", {31'd0, locked}, 32'd1);
    chk("window_err_count", {16'd0, err_count}, 32'd70);
    chk("window_lost", 32'(ll_cnt), 32'd0);
    send(1, 1);
    chk("clear_on_error", {16'd0, err_count}, 32'd0);
    chk("clear_pulse", {31'd0, bit_error}, 32'd1);
    // clear with no valid bit
    for (int i = 0; i < 3; i++) send(1, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("clear_idle", {16'd0, err_count}, 32'd0);

    // 6: random valid gaps lock at the same valid-bit count
    do_reset();
    while (vcnt < 60) begin
      if ($urandom_range(0, 1) == 1) send(0, 0);
      else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("gapped_lock_point", 32'(lock_at), 32'd24);
    send(1, 0);
    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_bit_error", {31'd0, bit_error}, 32'd0);
    chk("async_err_count", {16'd0, err_count}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    gi = 0; prev_locked = 0; mark();
    for (int i = 0; i < 30; i++) send(0, 0);
    chk("post_reset_lock", 32'(lock_at), 32'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
